// File: rtl/cavlc_defs_pkg.sv
// Shared definitions for the CAVLC coefficient statistics block.
//   - default widths (coefficient, run field, block depth)
//   - block type encodings and the type -> coefficient-count table
//   - FSM state type
//   - trailing-ones sign mask helper
package cavlc_defs;

    localparam int COEF_W_DEF = 9;
    localparam int MAX_N_DEF  = 16;
    localparam int RUN_W_DEF  = 4;

    localparam logic [1:0] BLK_16 = 2'b00;   // full 4x4 block
    localparam logic [1:0] BLK_15 = 2'b01;   // AC block, DC coded elsewhere
    localparam logic [1:0] BLK_4  = 2'b10;   // chroma DC 4:2:0
    localparam logic [1:0] BLK_8  = 2'b11;   // chroma DC 4:2:2

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_REPORT  = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    function automatic int unsigned blk_len(input logic [1:0] blk_type);
        case (blk_type)
            BLK_16:  return 16;
            BLK_15:  return 15;
            BLK_4:   return 4;
            BLK_8:   return 8;
            default: return 16;
        endcase
    endfunction

    // Keeps only the sign bits that belong to counted trailing ones.
    function automatic logic [2:0] t1_mask(input logic [1:0] n);
        case (n)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/cavlc_level_lifo.sv
// Level stack for the CAVLC statistics block.
// Holds {level, run_before} entries pushed in scan order so that they pop
// highest-frequency first.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low clear of the stack pointer
//   clr        synchronous clear (new block)
//   push       write push_data on top
//   push_data  entry to store
//   pop        discard the top entry
//   top_data   current top entry (undefined when count == 0)
//   count      number of entries held
// push and pop are never asserted together by the owner of this stack.
module cavlc_level_lifo #(
    parameter int DEPTH = 16,
    parameter int W     = 13,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     top_data,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic         do_push;

    assign do_push  = push && !clr && (count < CNT_W'(DEPTH));
    assign top_data = mem[AW'(count - CNT_W'(1))];

    // Storage is not reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[AW'(count)] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + CNT_W'(1);
        end else if (pop && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/cavlc_coeff_stats.sv
// CAVLC coefficient statistics stage.
// Takes one block of sign-magnitude coefficients in zig-zag order, computes
// TotalCoeff / TotalZeros / TrailingOnes / T1 signs as they stream in, then
// replays every nonzero level with its run_before, highest frequency first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for blk_start
// COLLECT | accepting coefficients until the block length is reached
// REPORT  | one cycle, stats_valid high, stats final
// DRAIN   | popping level entries to the level/run coders
//
// Ports:
//   clk, rst (async active-low)
//   blk_start, blk_type                      block framing
//   coef_valid, coef, coef_ready             coefficient input stream
//   stats_valid, total_coeff, total_zeros,
//   trail_ones, t1_signs                     block statistics
//   lvl_valid, lvl_ready, lvl_data, lvl_run,
//   lvl_is_t1, lvl_last                      level replay stream
module cavlc_coeff_stats
    import cavlc_defs::*;
#(
    parameter int COEF_W = COEF_W_DEF,
    parameter int MAX_N  = MAX_N_DEF,
    parameter int RUN_W  = RUN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_start,
    input  logic [1:0]        blk_type,
    input  logic              coef_valid,
    input  logic [COEF_W-1:0] coef,
    output logic              coef_ready,
    output logic              stats_valid,
    output logic [RUN_W:0]    total_coeff,
    output logic [RUN_W-1:0]  total_zeros,
    output logic [1:0]        trail_ones,
    output logic [2:0]        t1_signs,
    output logic              lvl_valid,
    input  logic              lvl_ready,
    output logic [COEF_W-1:0] lvl_data,
    output logic [RUN_W-1:0]  lvl_run,
    output logic              lvl_is_t1,
    output logic              lvl_last
);

    localparam int CNT_W = RUN_W + 1;
    localparam int MAG_W = COEF_W - 1;
    localparam int ENT_W = COEF_W + RUN_W;

    state_t            state;
    logic [CNT_W-1:0]  coef_left;   // down-counter, terminal count at 1
    logic [CNT_W-1:0]  tc_cnt;
    logic [RUN_W-1:0]  tz_cnt;
    logic [RUN_W-1:0]  pend_run;
    logic [1:0]        ones_run;
    logic [2:0]        t1_sh;
    logic [1:0]        t1_left;     // trailing-one entries still to be flagged

    logic              start_ok;
    logic              accept;
    logic              is_nz;
    logic              is_one;
    logic              push;
    logic              pop;

    logic [CNT_W-1:0]  tc_nxt;
    logic [RUN_W-1:0]  tz_nxt;
    logic [RUN_W-1:0]  pend_nxt;
    logic [1:0]        ones_nxt;
    logic [2:0]        sh_nxt;

    logic [ENT_W-1:0]  top_ent;
    logic [COEF_W-1:0] top_coef;
    logic [RUN_W-1:0]  top_run;
    logic [CNT_W-1:0]  lifo_count;

    assign coef_ready = (state == ST_COLLECT);
    assign start_ok   = blk_start && ((state == ST_IDLE) || (state == ST_COLLECT));
    // A restart wins over a coefficient offered in the same cycle.
    assign accept     = coef_ready && coef_valid && !blk_start;
    // -0 has zero magnitude and is treated as a zero.
    assign is_nz      = |coef[MAG_W-1:0];
    assign is_one     = (coef[MAG_W-1:0] == MAG_W'(1));
    assign push       = accept && is_nz;
    assign pop        = ((state == ST_REPORT) && (tc_cnt != '0)) ||
                        ((state == ST_DRAIN) && lvl_valid && lvl_ready && !lvl_last);

    assign top_coef   = top_ent[ENT_W-1:RUN_W];
    assign top_run    = top_ent[RUN_W-1:0];

    always_comb begin
        tc_nxt   = tc_cnt;
        tz_nxt   = tz_cnt;
        pend_nxt = pend_run;
        ones_nxt = ones_run;
        sh_nxt   = t1_sh;
        if (is_nz) begin
            tc_nxt   = tc_cnt + CNT_W'(1);
            // Zeros only count once a nonzero follows them, so trailing
            // zeros never reach total_zeros.
            tz_nxt   = tz_cnt + pend_run;
            pend_nxt = '0;
            if (is_one) begin
                ones_nxt = (ones_run == 2'd3) ? 2'd3 : ones_run + 2'd1;
                sh_nxt   = {t1_sh[1:0], coef[COEF_W-1]};
            end else begin
                ones_nxt = 2'd0;
                sh_nxt   = 3'b000;
            end
        end else begin
            pend_nxt = pend_run + RUN_W'(1);
        end
    end

    cavlc_level_lifo #(
        .DEPTH (MAX_N),
        .W     (ENT_W),
        .CNT_W (CNT_W)
    ) u_lifo (
        .clk       (clk),
        .rst_n     (rst),
        .clr       (start_ok),
        .push      (push),
        .push_data ({coef, pend_run}),
        .pop       (pop),
        .top_data  (top_ent),
        .count     (lifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            coef_left   <= '0;
            tc_cnt      <= '0;
            tz_cnt      <= '0;
            pend_run    <= '0;
            ones_run    <= 2'd0;
            t1_sh       <= 3'b000;
            t1_left     <= 2'd0;
            stats_valid <= 1'b0;
            total_coeff <= '0;
            total_zeros <= '0;
            trail_ones  <= 2'd0;
            t1_signs    <= 3'b000;
            lvl_valid   <= 1'b0;
            lvl_data    <= '0;
            lvl_run     <= '0;
            lvl_is_t1   <= 1'b0;
            lvl_last    <= 1'b0;
        end else begin
            stats_valid <= 1'b0;
            if (start_ok) begin
                state       <= ST_COLLECT;
                coef_left   <= CNT_W'(blk_len(blk_type));
                tc_cnt      <= '0;
                tz_cnt      <= '0;
                pend_run    <= '0;
                ones_run    <= 2'd0;
                t1_sh       <= 3'b000;
                total_coeff <= '0;
                total_zeros <= '0;
                trail_ones  <= 2'd0;
                t1_signs    <= 3'b000;
            end else begin
                case (state)
                    ST_COLLECT: begin
                        if (accept) begin
                            tc_cnt    <= tc_nxt;
                            tz_cnt    <= tz_nxt;
                            pend_run  <= pend_nxt;
                            ones_run  <= ones_nxt;
                            t1_sh     <= sh_nxt;
                            coef_left <= coef_left - CNT_W'(1);
                            if (coef_left == CNT_W'(1)) begin
                                state       <= ST_REPORT;
                                stats_valid <= 1'b1;
                                total_coeff <= tc_nxt;
                                total_zeros <= tz_nxt;
                                trail_ones  <= ones_nxt;
                                t1_signs    <= sh_nxt & t1_mask(ones_nxt);
                            end
                        end
                    end
                    ST_REPORT: begin
                        if (tc_cnt != '0) begin
                            state     <= ST_DRAIN;
                            lvl_valid <= 1'b1;
                            lvl_data  <= top_coef;
                            lvl_run   <= top_run;
                            lvl_last  <= (lifo_count == CNT_W'(1));
                            lvl_is_t1 <= (trail_ones != 2'd0);
                            t1_left   <= (trail_ones != 2'd0) ? trail_ones - 2'd1 : 2'd0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        if (lvl_valid && lvl_ready) begin
                            if (lvl_last) begin
                                state     <= ST_IDLE;
                                lvl_valid <= 1'b0;
                                lvl_data  <= '0;
                                lvl_run   <= '0;
                                lvl_is_t1 <= 1'b0;
                                lvl_last  <= 1'b0;
                                t1_left   <= 2'd0;
                            end else begin
                                lvl_data  <= top_coef;
                                lvl_run   <= top_run;
                                lvl_last  <= (lifo_count == CNT_W'(1));
                                lvl_is_t1 <= (t1_left != 2'd0);
                                t1_left   <= (t1_left != 2'd0) ? t1_left - 2'd1 : 2'd0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
